// File: rtl/ara_inval_responder.sv
// Turns byte-address write snoops from the vector unit into line invalidations for the L1 D-cache.
// Back-to-back writes to the line most recently queued are merged into that entry.
module ara_inval_responder #(
    parameter int AddrWidth   = 64,
    parameter int L1LineWidth = 16,
    parameter int Depth       = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 inval_valid_i,
    input  logic [AddrWidth-1:0] inval_addr_i,
    output logic                 inval_ready_o,
    output logic                 dc_inval_req_o,
    output logic [AddrWidth-1:0] dc_inval_addr_o,
    input  logic                 dc_inval_gnt_i,
    output logic                 busy_o,
    output logic [15:0]          coal_cnt_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int OffW = $clog2(L1LineWidth);
    localparam int CntW = PtrW + 1;

    function automatic logic [AddrWidth-1:0] line_align(input logic [AddrWidth-1:0] a);
        logic [AddrWidth-1:0] r;
        r           = a;
        r[OffW-1:0] = '0;
        return r;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [AddrWidth-1:0] mem [Depth];
    logic [PtrW-1:0]      wr_ptr;
    logic [PtrW-1:0]      rd_ptr;
    logic [CntW-1:0]      count;
    logic [15:0]          coal_cnt;

    logic [AddrWidth-1:0] line;
    logic [AddrWidth-1:0] tail;
    logic                 nonempty;
    logic                 pop;
    logic                 hit;
    logic                 ready;
    logic                 accept;
    logic                 push;

    // A merge into the tail is refused when that tail is the single entry leaving this
    // cycle: the D-cache may already have invalidated the line before the new write landed.
    always_comb begin
        line     = line_align(inval_addr_i);
        tail     = mem[wr_ptr - PtrW'(1)];
        nonempty = (count != '0);
        pop      = nonempty & dc_inval_gnt_i;
        hit      = en_i & nonempty & (line == tail) & !((count == CntW'(1)) & pop);
        ready    = !en_i | (count < CntW'(Depth)) | hit;
        accept   = inval_valid_i & ready;
        push     = accept & en_i & !hit;
    end

    assign inval_ready_o   = ready;
    assign dc_inval_req_o  = nonempty;
    assign busy_o          = nonempty;
    assign dc_inval_addr_o = nonempty ? mem[rd_ptr] : '0;
    assign coal_cnt_o      = coal_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            coal_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PtrW'(1);
            if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
            case ({push, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
            if (accept & hit) coal_cnt <= sat_inc(coal_cnt);
        end
    end

    // Storage is data only; occupancy alone decides which slots are meaningful.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= line;
    end

endmodule
